// File: rtl/crc_check_mvb.sv
// Serial CRC checker with optional even-parity bit: accumulates an MSB-first data
// stream, then compares the received check sequence against the computed one.
module crc_check_mvb #(
  parameter int                 CRC_W         = 7,
  parameter logic [CRC_W-1:0]   POLY          = 'h65,
  parameter logic [CRC_W-1:0]   INIT          = '0,
  parameter logic [CRC_W-1:0]   XOR_OUT       = '0,
  parameter int                 PARITY_EN     = 1,
  parameter int                 MAX_DATA_BITS = 64,
  parameter int                 ERR_CNT_W     = 16
) (
  input  logic                 clk_3M,
  input  logic                 rst,
  input  logic                 crc_ready,
  input  logic                 crc_read,
  input  logic                 data_valid,
  input  logic                 data_in,
  output logic                 crc_done,
  output logic                 crc_error,
  output logic                 frame_abort,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int CHK_W  = CRC_W + ((PARITY_EN != 0) ? 1 : 0);
  localparam int DCNT_W = $clog2(MAX_DATA_BITS + 2);
  localparam int CCNT_W = $clog2(CHK_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, CHECK, DONE} state_t;

  state_t             state, state_nx;
  logic [CRC_W-1:0]   crc_q, crc_step, crc_x;
  logic               par_q;
  logic [DCNT_W-1:0]  dcnt_q;
  logic [CCNT_W-1:0]  ccnt_q;
  logic [CHK_W-1:0]   rx_q, rx_nx, expected;
  logic               start, abort, take_data, take_chk, finish;
  logic               ovf, frame_err;

  assign crc_step  = {crc_q[CRC_W-2:0], 1'b0} ^ ((crc_q[CRC_W-1] ^ data_in) ? POLY : '0);
  assign crc_x     = crc_q ^ XOR_OUT;
  assign rx_nx     = {rx_q[CHK_W-2:0], data_in};
  assign ovf       = dcnt_q > DCNT_W'(MAX_DATA_BITS);
  assign frame_err = (rx_nx != expected) | ovf;
  assign crc_done  = (state == DONE);

  // Parity covers data bits and the transmitted CRC bits, giving even total parity.
  generate
    if (PARITY_EN != 0) begin : g_par
      assign expected = {crc_x, par_q ^ (^crc_x)};
    end else begin : g_nopar
      assign expected = crc_x;
    end
  endgenerate

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    abort     = 1'b0;
    take_data = 1'b0;
    take_chk  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:
        if (crc_ready && !crc_read) begin
          state_nx = DATA;
          start    = 1'b1;
        end
      DATA:
        if (!crc_ready) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (crc_read) begin
          // A strobe on the phase-change cycle is already the first check bit.
          state_nx = CHECK;
          take_chk = data_valid;
        end else begin
          take_data = data_valid;
        end
      CHECK:
        if (!crc_ready) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (!crc_read) begin
          abort    = 1'b1;
          start    = 1'b1;
          state_nx = DATA;
        end else begin
          take_chk = data_valid;
        end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (take_chk && ccnt_q == CCNT_W'(CHK_W - 1)) begin
      finish   = 1'b1;
      state_nx = DONE;
    end
  end

  always_ff @(posedge clk_3M or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      crc_q       <= INIT;
      par_q       <= 1'b0;
      dcnt_q      <= '0;
      ccnt_q      <= '0;
      rx_q        <= '0;
      crc_error   <= 1'b0;
      frame_abort <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_nx;
      frame_abort <= abort;
      if (start) begin
        crc_q     <= INIT;
        par_q     <= 1'b0;
        dcnt_q    <= '0;
        ccnt_q    <= '0;
        rx_q      <= '0;
        crc_error <= 1'b0;
      end
      if (take_data) begin
        crc_q <= crc_step;
        par_q <= par_q ^ data_in;
        if (dcnt_q != DCNT_W'(MAX_DATA_BITS + 1)) dcnt_q <= dcnt_q + 1'b1;
      end
      if (take_chk) begin
        rx_q   <= rx_nx;
        ccnt_q <= ccnt_q + 1'b1;
      end
      // Result is registered on the edge taking the last check bit, so it is
      // already valid while crc_done is high.
      if (finish) begin
        crc_error <= frame_err;
        if (frame_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_crc_check_mvb.sv
// Randomized scoreboard bench for crc_check_mvb: reference CRC by polynomial long division.
module tb_crc_check_mvb;
  localparam int EW = 4;

  logic clk_3M = 1'b0, rst = 1'b0;
  logic crc_ready = 1'b0, crc_read = 1'b0, data_valid = 1'b0, data_in = 1'b0;
  logic crc_done, crc_error, frame_abort;
  logic [EW-1:0] err_cnt;

  crc_check_mvb #(.ERR_CNT_W(EW)) dut (
    .clk_3M(clk_3M), .rst(rst), .crc_ready(crc_ready), .crc_read(crc_read),
    .data_valid(data_valid), .data_in(data_in), .crc_done(crc_done),
    .crc_error(crc_error), .frame_abort(frame_abort), .err_cnt(err_cnt)
  );

  always #5 clk_3M = ~clk_3M;

  typedef bit bq_t[$];
  typedef struct { bit abort; bit err; logic [EW-1:0] cnt; } exp_t;

  exp_t sb[$];
  exp_t e;
  int n_tests = 0, n_fail = 0;
  int m_cnt = 0;

  // Remainder of M(x)*x^7 mod G(x), G = x^7+x^6+x^5+x^2+1, then even parity bit.
  function automatic logic [7:0] ref_chk(input bq_t d);
    bq_t r;
    logic [7:0] g;
    logic [6:0] crc;
    bit p;
    g = 8'hE5;
    r = d;
    for (int i = 0; i < 7; i++) r.push_back(1'b0);
    for (int i = 0; i < d.size(); i++)
      if (r[i]) for (int j = 0; j < 8; j++) r[i+j] = r[i+j] ^ g[7-j];
    for (int j = 0; j < 7; j++) crc[6-j] = r[d.size()+j];
    p = ^crc;
    foreach (d[i]) p = p ^ d[i];
    return {crc, p};
  endfunction

  function automatic void push_exp(input bit abort, input bit err);
    exp_t x;
    if (!abort && err && m_cnt < (1 << EW) - 1) m_cnt++;
    x.abort = abort; x.err = err; x.cnt = m_cnt[EW-1:0];
    sb.push_back(x);
  endfunction

  always @(negedge clk_3M) begin
    if (rst && (crc_done || frame_abort)) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got done=%0b abort=%0b, expected no pulse", crc_done, frame_abort);
      end else begin
        e = sb.pop_front();
        if (frame_abort !== e.abort || crc_done !== !e.abort || err_cnt !== e.cnt ||
            (!e.abort && crc_error !== e.err)) begin
          n_fail++;
          $display("FAIL frame_result: got done=%0b abort=%0b err=%0b cnt=%0d, expected done=%0b abort=%0b err=%0b cnt=%0d",
                   crc_done, frame_abort, crc_error, err_cnt, !e.abort, e.abort, e.err, e.cnt);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit rdy, input bit rd, input bit v, input bit d);
    @(negedge clk_3M);
    crc_ready = rdy; crc_read = rd; data_valid = v; data_in = d;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(1));
  endfunction

  // mode 0: full frame; 1: drop crc_ready after k check bits; 2: drop crc_read after k check bits
  task automatic frame(input bq_t d, input logic [7:0] chk, input int mode, input int k,
                       input bit started, input bit rnd);
    if (!started) cyc(1, 0, rnd ? rb() : 1'b0, rb());
    foreach (d[i]) begin
      if (rnd && $urandom_range(3) == 0) cyc(1, 0, 0, rb());
      cyc(1, 0, 1, d[i]);
    end
    if (mode == 0) begin
      push_exp(0, (chk != ref_chk(d)) || d.size() > 64);
      for (int i = 0; i < 8; i++) begin
        if (rnd && $urandom_range(3) == 0) cyc(1, 1, 0, rb());
        cyc(1, 1, 1, chk[7-i]);
      end
      cyc(0, 0, rnd ? rb() : 1'b0, rb());
      cyc(0, 0, 0, 0);
    end else begin
      for (int i = 0; i < k; i++) cyc(1, 1, 1, chk[7-i]);
      push_exp(1, 0);
      if (mode == 1) begin
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
      end else begin
        cyc(1, 0, rb(), rb());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_3M);
    crc_ready = 0; crc_read = 0; data_valid = 0;
    rst = 0;
    m_cnt = 0;
    #1;
    check("reset_outputs", {28'd0, crc_done, crc_error, frame_abort, 1'b0}, 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    repeat (2) @(negedge clk_3M);
    rst = 1;
  endtask

  function automatic bq_t zeros(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(1'b0);
    return q;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bq_t d, one;
    logic [7:0] c;
    int mode, k;
    bit pend;
    one.push_back(1'b1);
    repeat (2) @(negedge clk_3M);
    check("init_reset_outputs", {28'd0, crc_done, crc_error, frame_abort, 1'b0}, 32'd0);
    check("init_reset_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1;
    cyc(0, 0, 0, 0);

    frame(zeros(16), 8'h00, 0, 0, 0, 0);
    check("ref_model_one", 32'(ref_chk(one)), 32'hCB);
    frame(one, 8'hCB, 0, 0, 0, 0);
    frame(one, 8'hCA, 0, 0, 0, 0);
    frame(zeros(65), 8'h00, 0, 0, 0, 0);
    frame(zeros(64), 8'h00, 0, 0, 0, 0);
    frame(d, 8'h00, 0, 0, 0, 0);
    frame(zeros(5), 8'h00, 1, 3, 0, 0);

    // Reset while in CHECK discards the frame silently.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0);
    do_reset();
    frame(zeros(8), 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) frame(one, 8'hCA, 0, 0, 0, 0);
    check("err_cnt_saturated", 32'(err_cnt), 32'hF);
    do_reset();

    pend = 0;
    for (int n = 0; n < 60; n++) begin
      d = {};
      k = ($urandom_range(5) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 24);
      for (int i = 0; i < k; i++) d.push_back(rb());
      c = ref_chk(d);
      if ($urandom_range(2) == 0) c = c ^ (8'd1 << $urandom_range(7));
      mode = (pend || $urandom_range(5) > 1) ? 0 : $urandom_range(1, 2);
      k = (mode == 2) ? $urandom_range(1, 7) : $urandom_range(0, 7);
      frame(d, c, mode, k, pend, 1);
      pend = (mode == 2);
    end
    if (pend) frame(zeros(3), 8'h00, 0, 0, 1, 0);

    repeat (5) cyc(0, 0, 0, 0);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/crc_check_mvb.md
CRC_CHECK_MVB -- requirements
Module: crc_check_mvb

Interface
REQ-001 SHALL have parameter CRC_W, default 7, CRC register width in bits.
REQ-002 SHALL have parameter POLY, default 7'h65, generator polynomial without its implicit x^CRC_W term; default is x^7+x^6+x^5+x^2+1.
REQ-003 SHALL have parameter INIT, default 0, CRC register value at frame start.
REQ-004 SHALL have parameter XOR_OUT, default 0, value XORed onto the CRC before comparison.
REQ-005 SHALL have parameter PARITY_EN, default 1, which appends an even-parity bit to the check sequence; CHK_W = CRC_W + PARITY_EN.
REQ-006 SHALL have parameter MAX_DATA_BITS, default 64, the maximum number of data bits per frame.
REQ-007 SHALL have parameter ERR_CNT_W, default 16, the error counter width.
REQ-008 clk_3M  in  1  sole clock; all state changes on the rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 crc_ready  in  1  frame enable; high for the whole frame.
REQ-011 crc_read  in  1  low = data phase; high = check-sequence phase.
REQ-012 data_valid  in  1  bit strobe; data_in is sampled only when this is high.
REQ-013 data_in  in  1  serial bit, MSB first.
REQ-014 crc_done  out  1  one-cycle pulse when a frame check completes.
REQ-015 crc_error  out  1  result of the last completed frame; 1 = mismatch or overflow.
REQ-016 frame_abort  out  1  one-cycle pulse when a frame is abandoned.
REQ-017 err_cnt  out  ERR_CNT_W  saturating count of frames that completed with an error.

Function
REQ-018 The state machine SHALL have the states IDLE, DATA, CHECK and DONE.
REQ-019 IDLE->DATA SHALL occur when crc_ready=1 and crc_read=0; on entry the CRC register loads INIT, the bit counters clear and crc_error clears.
REQ-020 In DATA, each data_valid=1 cycle SHALL perform one LFSR step:
- fb = crc[CRC_W-1]^data_in
- crc = {crc[CRC_W-2:0],0} ^ (fb ? POLY : 0)
- running parity ^= data_in
- data counter +1
REQ-021 The data counter SHALL saturate at MAX_DATA_BITS+1; a value above MAX_DATA_BITS sets an internal overflow flag.
REQ-022 DATA->CHECK SHALL occur when crc_read=1 and crc_ready=1.
REQ-023 A data_valid bit present in the same cycle as the DATA->CHECK transition SHALL be treated as check bit 0.
REQ-024 In CHECK, each data_valid=1 cycle SHALL shift data_in into the received register MSB first; CHK_W bits are expected.
REQ-025 The expected check sequence SHALL be {crc^XOR_OUT, p}.
- p = XOR of all data bits and all bits of (crc^XOR_OUT), so total parity is even.
- p is omitted when PARITY_EN=0.
REQ-026 After the CHK_W-th accepted bit, the block SHALL enter DONE on the next edge.
REQ-027 In DONE, for exactly one cycle:
- crc_done=1
- crc_error = (received != expected) | overflow
- err_cnt +1 if error, saturating at all-ones
- state then goes to IDLE.
REQ-028 crc_error SHALL hold its value from DONE until the next IDLE->DATA transition.
REQ-029 Abort: crc_ready=0 in DATA or CHECK, or crc_read=0 in CHECK, SHALL pulse frame_abort for one cycle and return to IDLE.
- crc_done stays 0 and err_cnt is unchanged.
- An abort caused by crc_read=0 with crc_ready=1 SHALL go directly to DATA of a new frame.
REQ-030 data_valid in IDLE or DONE SHALL be ignored.
REQ-031 A frame with zero data bits SHALL be legal; the expected check sequence is {INIT^XOR_OUT, parity}.
REQ-032 Latency SHALL be: crc_done one cycle after the edge that accepts the last check bit.

Reset
REQ-033 On rst=0, asynchronously and regardless of state:
- state=IDLE
- CRC register = INIT, counters = 0
- crc_done=0, crc_error=0, frame_abort=0, err_cnt=0.
REQ-034 Reset mid-frame SHALL discard the frame with no done or abort pulse.
REQ-035 The first frame after reset release SHALL start only on a fresh IDLE->DATA condition.

Verification
REQ-036 16 zero data bits, check 8'h00 -> crc_done pulse, crc_error=0, err_cnt=0.
REQ-037 1 data bit '1', check 8'hCB (crc 7'h65, parity 1) -> crc_error=0; same frame with check 8'hCA -> crc_error=1, err_cnt=1.
REQ-038 65 zero data bits with MAX_DATA_BITS=64, check 8'h00 -> crc_error=1 (overflow).
REQ-039 crc_ready dropped after 3 check bits -> frame_abort pulse, no crc_done, err_cnt unchanged.
REQ-040 rst asserted during CHECK -> all outputs 0 immediately; next 8 zero data bits plus check 8'h00 -> crc_error=0.
REQ-041 err_cnt preloaded to all-ones by 2^ERR_CNT_W bad frames (ERR_CNT_W=4, i.e. 16 frames), then one more bad frame -> err_cnt stays 4'hF.
